// File: rtl/spl_mem_responder.sv
// spl_mem_responder: DEPTH x 512-bit line memory answering SPL read/write requests
// through independent in-order response queues.
module spl_mem_responder #(
    parameter int DEPTH    = 64,
    parameter int RQ_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         spl_rd_req_valid,
    output logic         spl_rd_req_ready,
    input  logic [79:0]  spl_rd_req_data,
    output logic         spl_rd_resp_valid,
    input  logic         spl_rd_resp_ready,
    output logic [527:0] spl_rd_resp_data,
    input  logic         spl_wr_req_valid,
    output logic         spl_wr_req_ready,
    input  logic [605:0] spl_wr_req_data,
    output logic         spl_wr_resp_valid,
    input  logic         spl_wr_resp_ready,
    output logic [16:0]  spl_wr_resp_data,
    output logic         idle
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(RQ_DEPTH);
    localparam int CW = PW + 1;

    logic [511:0]  mem    [DEPTH];
    logic [527:0]  rq_mem [RQ_DEPTH];
    logic [16:0]   wq_mem [RQ_DEPTH];
    logic          st_valid;
    logic [15:0]   st_tag;
    logic [511:0]  st_data;
    logic [PW-1:0] rq_wptr, rq_rptr, wq_wptr, wq_rptr;
    logic [CW-1:0] rq_cnt, wq_cnt;
    logic          rd_fire, wr_fire, rq_pop, wq_pop, rd_in, wr_in;
    logic [63:0]   rd_addr, wr_addr;
    logic          unused_wr_bits;

    assign rd_addr        = spl_rd_req_data[63:0];
    assign wr_addr        = spl_wr_req_data[575:512];
    assign rd_in          = rd_addr < 64'(DEPTH);
    assign wr_in          = wr_addr < 64'(DEPTH);
    assign unused_wr_bits = ^spl_wr_req_data[605:592];

    // The stage slot is reserved in the read-queue budget so a staged read always has room to land.
    assign spl_rd_req_ready  = rst && (rq_cnt + CW'(st_valid)) < CW'(RQ_DEPTH);
    assign spl_wr_req_ready  = rst && wq_cnt < CW'(RQ_DEPTH);
    assign rd_fire           = spl_rd_req_valid && spl_rd_req_ready;
    assign wr_fire           = spl_wr_req_valid && spl_wr_req_ready;
    assign spl_rd_resp_valid = rq_cnt != '0;
    assign spl_wr_resp_valid = wq_cnt != '0;
    assign rq_pop            = spl_rd_resp_valid && spl_rd_resp_ready;
    assign wq_pop            = spl_wr_resp_valid && spl_wr_resp_ready;
    assign spl_rd_resp_data  = rq_mem[rq_rptr];
    assign spl_wr_resp_data  = wq_mem[wq_rptr];
    assign idle              = rst && !st_valid && rq_cnt == '0 && wq_cnt == '0;

    // Storage is never reset; a same-edge write is invisible to the read because both use old mem.
    always_ff @(posedge clk) begin
        if (wr_fire && wr_in)
            mem[wr_addr[AW-1:0]] <= spl_wr_req_data[511:0];
        if (rd_fire) begin
            st_tag  <= spl_rd_req_data[79:64];
            st_data <= rd_in ? mem[rd_addr[AW-1:0]] : '0;
        end
        if (st_valid)
            rq_mem[rq_wptr] <= {st_tag, st_data};
        if (wr_fire)
            wq_mem[wq_wptr] <= {!wr_in, spl_wr_req_data[591:576]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_valid <= 1'b0;
            rq_wptr  <= '0;
            rq_rptr  <= '0;
            rq_cnt   <= '0;
            wq_wptr  <= '0;
            wq_rptr  <= '0;
            wq_cnt   <= '0;
        end else begin
            st_valid <= rd_fire;
            rq_wptr  <= rq_wptr + PW'(st_valid);
            rq_rptr  <= rq_rptr + PW'(rq_pop);
            rq_cnt   <= rq_cnt + CW'(st_valid) - CW'(rq_pop);
            wq_wptr  <= wq_wptr + PW'(wr_fire);
            wq_rptr  <= wq_rptr + PW'(wq_pop);
            wq_cnt   <= wq_cnt + CW'(wr_fire) - CW'(wq_pop);
        end
    end
endmodule

// File: tb/tb_spl_mem_responder.sv
// tb_spl_mem_responder: directed vector table, multi-cycle corner sequences and a
// randomized scoreboard run against a behavioural memory model.
module tb_spl_mem_responder;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rd_v = 1'b0, rr = 1'b0, wr_v = 1'b0, wr_rr = 1'b0;
    logic [79:0]  rd_d = '0;
    logic [605:0] wr_d = '0;
    logic         rd_rdy, rd_rv, wr_rdy, wr_rv, idle;
    logic [527:0] rd_rd;
    logic [16:0]  wr_rd;

    int tests = 0, fails = 0, cyc = 0;

    spl_mem_responder dut (
        .clk(clk), .rst(rst),
        .spl_rd_req_valid(rd_v), .spl_rd_req_ready(rd_rdy), .spl_rd_req_data(rd_d),
        .spl_rd_resp_valid(rd_rv), .spl_rd_resp_ready(rr), .spl_rd_resp_data(rd_rd),
        .spl_wr_req_valid(wr_v), .spl_wr_req_ready(wr_rdy), .spl_wr_req_data(wr_d),
        .spl_wr_resp_valid(wr_rv), .spl_wr_resp_ready(wr_rr), .spl_wr_resp_data(wr_rd),
        .idle(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [527:0] act, input logic [527:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] fill_val(input int i);
        return {16{32'hC0DE0000 | 32'(i)}};
    endfunction

    // Scoreboard: behavioural memory plus expected-response queues, all sampled mid-cycle.
    logic [511:0] model [64];
    logic [527:0] rq[$];
    logic [16:0]  wq[$];
    logic [63:0]  mon_a;
    logic         rd_hold = 1'b0, wr_hold = 1'b0;
    logic [527:0] rd_hold_d;
    logic [16:0]  wr_hold_d;

    always @(negedge clk) begin
        if (!rst) begin
            rq.delete();
            wq.delete();
            rd_hold = 1'b0;
            wr_hold = 1'b0;
        end else begin
            if (rd_hold) begin
                chk("rd_hold_valid", 528'(rd_rv), 528'(1));
                chk("rd_hold_data", rd_rd, rd_hold_d);
            end
            if (wr_hold) begin
                chk("wr_hold_valid", 528'(wr_rv), 528'(1));
                chk("wr_hold_data", 528'(wr_rd), 528'(wr_hold_d));
            end
            rd_hold = rd_rv && !rr;
            rd_hold_d = rd_rd;
            wr_hold = wr_rv && !wr_rr;
            wr_hold_d = wr_rd;
            if (rd_rv && rr) begin
                chk("rd_unexpected_resp", 528'(rq.size() > 0), 528'(1));
                if (rq.size() > 0) chk("rd_sb", rd_rd, rq.pop_front());
            end
            if (wr_rv && wr_rr) begin
                chk("wr_unexpected_resp", 528'(wq.size() > 0), 528'(1));
                if (wq.size() > 0) chk("wr_sb", 528'(wr_rd), 528'(wq.pop_front()));
            end
            if (rd_v && rd_rdy) begin
                mon_a = rd_d[63:0];
                rq.push_back({rd_d[79:64], mon_a < 64 ? model[mon_a[5:0]] : 512'b0});
            end
            if (wr_v && wr_rdy) begin
                mon_a = wr_d[575:512];
                wq.push_back({mon_a >= 64, wr_d[591:576]});
                if (mon_a < 64) model[mon_a[5:0]] = wr_d[511:0];
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_rd(input logic [63:0] a, input logic [15:0] t, output int e);
        rd_v = 1'b1;
        rd_d = {t, a};
        e = -1;
        for (int i = 0; i < 200 && e < 0; i++) begin
            @(negedge clk);
            if (rd_rdy) e = cyc + 1;
            @(posedge clk); #1;
        end
        rd_v = 1'b0;
        chk("rd_req_timeout", 528'(e >= 0), 528'(1));
    endtask

    task automatic send_wr(input logic [63:0] a, input logic [511:0] d, input logic [15:0] t, output int e);
        wr_v = 1'b1;
        wr_d = {14'h0, t, a, d};
        e = -1;
        for (int i = 0; i < 200 && e < 0; i++) begin
            @(negedge clk);
            if (wr_rdy) e = cyc + 1;
            @(posedge clk); #1;
        end
        wr_v = 1'b0;
        chk("wr_req_timeout", 528'(e >= 0), 528'(1));
    endtask

    task automatic wait_rd(output logic [527:0] d, output int e);
        e = -1;
        d = '0;
        for (int i = 0; i < 50 && e < 0; i++) begin
            @(negedge clk);
            if (rd_rv && rr) begin d = rd_rd; e = cyc + 1; end
            @(posedge clk); #1;
        end
        chk("rd_resp_timeout", 528'(e >= 0), 528'(1));
    endtask

    task automatic wait_wr(output logic [16:0] d, output int e);
        e = -1;
        d = '0;
        for (int i = 0; i < 50 && e < 0; i++) begin
            @(negedge clk);
            if (wr_rv && wr_rr) begin d = wr_rd; e = cyc + 1; end
            @(posedge clk); #1;
        end
        chk("wr_resp_timeout", 528'(e >= 0), 528'(1));
    endtask

    bit rdone, wdone;

    task automatic rand_rd(input int n);
        int e;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_rd(64'($urandom_range(0, 71)), 16'(16'h4000 + k), e);
        end
        rdone = 1'b1;
    endtask

    task automatic rand_wr(input int n);
        int e;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_wr(64'($urandom_range(0, 71)), {16{32'($urandom)}}, 16'(16'h8000 + k), e);
        end
        wdone = 1'b1;
    endtask

    typedef struct {
        string        name;
        bit           is_wr;
        logic [63:0]  addr;
        logic [511:0] data;
        logic [15:0]  tag;
        logic [527:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int ea, eb, acc;
        logic [527:0] gr;
        logic [16:0]  gw;
        logic [511:0] pat_a5, pat_x;
        pat_a5 = {64{8'hA5}};
        pat_x  = {8{64'hDEAD_BEEF_0123_4567}};
        vecs[0] = '{"wr_a5",      1, 64'd5,             pat_a5,       16'h0011, 528'(17'h00011)};
        vecs[1] = '{"rd_a5",      0, 64'd5,             '0,           16'h0022, {16'h0022, pat_a5}};
        vecs[2] = '{"wr_oor64",   1, 64'd64,            {64{8'hFF}},  16'h0033, 528'(17'h10033)};
        vecs[3] = '{"rd_oor64",   0, 64'd64,            '0,           16'h0034, {16'h0034, 512'b0}};
        vecs[4] = '{"rd_addr0",   0, 64'd0,             '0,           16'h0035, {16'h0035, fill_val(0)}};
        vecs[5] = '{"wr_top",     1, 64'd63,            pat_x,        16'h0040, 528'(17'h00040)};
        vecs[6] = '{"rd_top",     0, 64'd63,            '0,           16'h0041, {16'h0041, pat_x}};
        vecs[7] = '{"rd_oor_max", 0, 64'hFFFF_FFFF_FFFF_FFFF, '0,     16'h0042, {16'h0042, 512'b0}};
        vecs[8] = '{"wr_oor_hi",  1, 64'h1_0000_0005,   {64{8'h3C}},  16'h0043, 528'(17'h10043)};
        vecs[9] = '{"rd_a5_keep", 0, 64'd5,             '0,           16'h0044, {16'h0044, pat_a5}};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_req_ready", 528'(rd_rdy), 528'(0));
        chk("rst_wr_req_ready", 528'(wr_rdy), 528'(0));
        chk("rst_idle", 528'(idle), 528'(0));
        chk("rst_valids", 528'({rd_rv, wr_rv}), 528'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 528'({rd_rdy, wr_rdy}), 528'(2'b11));
        chk("post_rst_idle", 528'(idle), 528'(1));
        @(posedge clk); #1;
        rr = 1'b1;
        wr_rr = 1'b1;

        for (int i = 0; i < 64; i++) send_wr(64'(i), fill_val(i), 16'(i), ea);
        repeat (3) begin @(posedge clk); #1; end

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_wr) begin
                send_wr(vecs[i].addr, vecs[i].data, vecs[i].tag, ea);
                wait_wr(gw, eb);
                chk(vecs[i].name, 528'(gw), vecs[i].exp);
                chk({vecs[i].name, "_lat"}, 528'(eb - ea), 528'(1));
            end else begin
                send_rd(vecs[i].addr, vecs[i].tag, ea);
                wait_rd(gr, eb);
                chk(vecs[i].name, gr, vecs[i].exp);
                chk({vecs[i].name, "_lat"}, 528'(eb - ea), 528'(2));
            end
        end

        // Read back-pressure: only RQ_DEPTH reads may be outstanding.
        rr = 1'b0;
        rd_v = 1'b1;
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            rd_d = {16'(16'h0100 + acc), 64'(acc)};
            @(negedge clk);
            if (rd_rdy) acc++;
            @(posedge clk); #1;
        end
        rd_v = 1'b0;
        chk("bp_accepted", 528'(acc), 528'(4));
        @(negedge clk);
        chk("bp_ready_low", 528'(rd_rdy), 528'(0));
        @(posedge clk); #1;
        rr = 1'b1;
        for (int i = 0; i < 20 && !idle; i++) begin @(posedge clk); #1; end
        chk("bp_drain_idle", 528'(idle), 528'(1));
        chk("bp_ready_back", 528'(rd_rdy), 528'(1));
        chk("bp_sb_empty", 528'(rq.size()), 528'(0));

        // Same-edge read and write of one line.
        send_wr(64'd7, 512'h1, 16'h0050, ea);
        repeat (2) begin @(posedge clk); #1; end
        rd_v = 1'b1; rd_d = {16'h0051, 64'd7};
        wr_v = 1'b1; wr_d = {14'h0, 16'h0052, 64'd7, 512'h2};
        @(negedge clk);
        chk("same_edge_ready", 528'({rd_rdy, wr_rdy}), 528'(2'b11));
        @(posedge clk); #1;
        rd_v = 1'b0;
        wr_v = 1'b0;
        wait_rd(gr, eb);
        chk("same_edge_old", gr, {16'h0051, 512'h1});
        send_rd(64'd7, 16'h0053, ea);
        wait_rd(gr, eb);
        chk("after_write_new", gr, {16'h0053, 512'h2});

        // Reset with two reads queued and one in the stage register.
        rr = 1'b0;
        rd_v = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rd_d = {16'(16'h0200 + k), 64'(k + 10)};
            @(negedge clk);
            chk("rst_seq_ready", 528'(rd_rdy), 528'(1));
            @(posedge clk); #1;
        end
        rd_v = 1'b0;
        chk("pre_rst_valid", 528'(rd_rv), 528'(1));
        rst = 1'b0;
        #1;
        chk("mid_rst_valids", 528'({rd_rv, wr_rv}), 528'(0));
        chk("mid_rst_ready", 528'({rd_rdy, wr_rdy}), 528'(0));
        chk("mid_rst_idle", 528'(idle), 528'(0));
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rel_rst_idle", 528'(idle), 528'(1));
        chk("rel_rst_ready", 528'({rd_rdy, wr_rdy}), 528'(2'b11));
        @(posedge clk); #1;
        rr = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        chk("no_stale_rd", 528'(rd_rv), 528'(0));
        send_rd(64'd5, 16'h0060, ea);
        wait_rd(gr, eb);
        chk("post_rst_read", gr, {16'h0060, pat_a5});

        // Randomized traffic on all four channels, checked by the scoreboard.
        rdone = 1'b0;
        wdone = 1'b0;
        fork
            rand_rd(500);
            rand_wr(500);
            while (!(rdone && wdone)) begin
                @(posedge clk); #1;
                rr = 1'($urandom_range(0, 1));
                wr_rr = 1'($urandom_range(0, 1));
            end
        join
        rr = 1'b1;
        wr_rr = 1'b1;
        for (int i = 0; i < 30 && !idle; i++) begin @(posedge clk); #1; end
        chk("rand_rd_sb_empty", 528'(rq.size()), 528'(0));
        chk("rand_wr_sb_empty", 528'(wq.size()), 528'(0));
        @(negedge clk);
        chk("final_idle", 528'(idle), 528'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
